// File: rtl/jk_excitation_driver.sv
// Drives J/K of an external JK flip-flop so its Q follows a loaded target pattern (LSB first),
// checking each resulting Q against the target and counting mismatches.
module jk_excitation_driver #(
    parameter int LEN    = 8,
    parameter bit DC_VAL = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [LEN-1:0]          pattern,
    input  logic                    loop,
    input  logic                    abort,
    input  logic                    Q_fb,
    output logic                    J,
    output logic                    K,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [7:0]              err_count,
    output logic [$clog2(LEN)-1:0]  step
);

    localparam int SW = $clog2(LEN);
    localparam logic [SW-1:0] LAST = SW'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t          state_q;
    logic [LEN-1:0]  pat_q;
    logic [SW-1:0]   step_q;
    logic            exp_q;
    logic            chkValid_q;
    logic            err_q;
    logic [7:0]      errCount_q;
    logic            done_q;

    logic            curTarget;
    logic            mismatch;
    logic [7:0]      errCount_d;

    // Excitation table: hold when the target equals Q, otherwise set or reset.
    always_comb begin
        J         = 1'b0;
        K         = 1'b0;
        curTarget = pat_q[step_q];
        if (state_q == RUN) begin
            case ({Q_fb, curTarget})
                2'b00:   begin J = 1'b0;   K = DC_VAL; end
                2'b01:   begin J = 1'b1;   K = DC_VAL; end
                2'b10:   begin J = DC_VAL; K = 1'b1;   end
                default: begin J = DC_VAL; K = 1'b0;   end
            endcase
        end
    end

    // Q_fb seen here reflects the flip-flop update from the previous edge.
    always_comb begin
        mismatch   = chkValid_q && (Q_fb != exp_q);
        errCount_d = errCount_q;
        if (mismatch && (errCount_q != 8'hFF)) begin
            errCount_d = errCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            step_q     <= '0;
            exp_q      <= 1'b0;
            chkValid_q <= 1'b0;
            err_q      <= 1'b0;
            errCount_q <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (mismatch) begin
                err_q      <= 1'b1;
                errCount_q <= errCount_d;
            end
            case (state_q)
                IDLE: begin
                    if (load) begin
                        pat_q      <= pattern;
                        step_q     <= '0;
                        err_q      <= 1'b0;
                        errCount_q <= 8'd0;
                        chkValid_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    exp_q      <= curTarget;
                    chkValid_q <= 1'b1;
                    // Abort outranks the loop wrap.
                    if (abort) begin
                        state_q <= DRAIN;
                    end else if (step_q == LAST) begin
                        if (loop) begin
                            step_q <= '0;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                DRAIN: begin
                    chkValid_q <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_q == IDLE);
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = done_q;
    assign err       = err_q;
    assign err_count = errCount_q;
    assign step      = step_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver: two instances (DC_VAL=0 and DC_VAL=1), each closing
// the loop through its own behavioural JK flip-flop.
module tb_jk_excitation_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic       loop = 1'b0;
    logic       abort = 1'b0;
    logic       forceZero = 1'b0;

    logic       q0, q1;
    logic       fb0;
    logic       j0, k0, ready0, busy0, done0, err0;
    logic       j1, k1, ready1, busy1, done1, err1;
    logic [7:0] errCount0, errCount1;
    logic [2:0] step0, step1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign fb0 = forceZero ? 1'b0 : q0;

    jk_excitation_driver #(.LEN(8), .DC_VAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .load(load), .pattern(pattern), .loop(loop), .abort(abort),
        .Q_fb(fb0), .J(j0), .K(k0), .ready(ready0), .busy(busy0), .done(done0),
        .err(err0), .err_count(errCount0), .step(step0)
    );

    jk_excitation_driver #(.LEN(8), .DC_VAL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .pattern(pattern), .loop(loop), .abort(abort),
        .Q_fb(q1), .J(j1), .K(k1), .ready(ready1), .busy(busy1), .done(done1),
        .err(err1), .err_count(errCount1), .step(step1)
    );

    // External JK flip-flops under drive.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0 <= 1'b0;
            q1 <= 1'b0;
        end else begin
            case ({j0, k0})
                2'b01:   q0 <= 1'b0;
                2'b10:   q0 <= 1'b1;
                2'b11:   q0 <= ~q0;
                default: q0 <= q0;
            endcase
            case ({j1, k1})
                2'b01:   q1 <= 1'b0;
                2'b10:   q1 <= 1'b1;
                2'b11:   q1 <= ~q1;
                default: q1 <= q1;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulseReset();
        load = 1'b0; loop = 1'b0; abort = 1'b0; forceZero = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic startRun(input logic [7:0] pat, input logic lp);
        pattern = pat;
        loop    = lp;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; pattern = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ready0 !== 1'b1 || busy0 !== 1'b0 || {j0, k0} !== 2'b00 || done0 !== 1'b0 ||
                err0 !== 1'b0 || errCount0 !== 8'd0 || step0 !== 3'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold%0d got rdy=%b busy=%b jk=%b%b done=%b err=%b cnt=%0d want 1 0 00 0 0 0",
                         i, ready0, busy0, j0, k0, done0, err0, errCount0);
            end
        end
        load = 1'b0; rst = 1'b0;
        tick();
        checks++;
        if (ready0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release got rdy=%b busy=%b want 1 0", ready0, busy0);
        end
    endtask

    task automatic test_basic();
        logic [7:0] seq;
        seq = 8'hB2;
        pulseReset();
        startRun(8'hB2, 1'b0);
        checks++;
        if (ready0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_start got rdy=%b busy=%b want 0 1", ready0, busy0);
        end
        checks++;
        if ({j0, k0} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL basic_jk0 got %b%b want 00", j0, k0);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                checks++;
                if ({j0, k0} !== 2'b10) begin
                    errors++;
                    $display("[TB] FAIL basic_jk1 got %b%b want 10", j0, k0);
                end
            end
            if (i == 2) begin
                checks++;
                if ({j0, k0} !== 2'b01) begin
                    errors++;
                    $display("[TB] FAIL basic_jk2 got %b%b want 01", j0, k0);
                end
            end
            tick();
            checks++;
            if (q0 !== seq[i] || done0 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_q%0d got q=%b done=%b want q=%b done=0", i, q0, done0, seq[i]);
            end
        end
        tick();
        checks++;
        if (done0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0 || err0 !== 1'b0 || errCount0 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL basic_done got done=%b rdy=%b busy=%b err=%b cnt=%0d want 1 1 0 0 0",
                     done0, ready0, busy0, err0, errCount0);
        end
        tick();
        checks++;
        if (done0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done_width got %b want 0", done0);
        end
    endtask

    task automatic test_forced_error();
        pulseReset();
        forceZero = 1'b1;
        startRun(8'hB2, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (done0 !== 1'b1 || err0 !== 1'b1 || errCount0 !== 8'd4) begin
            errors++;
            $display("[TB] FAIL forced_err got done=%b err=%b cnt=%0d want 1 1 4", done0, err0, errCount0);
        end
        forceZero = 1'b0;
        tick();
        checks++;
        if (err0 !== 1'b1 || errCount0 !== 8'd4) begin
            errors++;
            $display("[TB] FAIL forced_hold got err=%b cnt=%0d want 1 4", err0, errCount0);
        end
        startRun(8'hB2, 1'b0);
        checks++;
        if (err0 !== 1'b0 || errCount0 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL forced_clear got err=%b cnt=%0d want 0 0", err0, errCount0);
        end
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (done0 !== 1'b1 || err0 !== 1'b0 || errCount0 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL forced_rerun got done=%b err=%b cnt=%0d want 1 0 0", done0, err0, errCount0);
        end
    endtask

    task automatic test_dc_val();
        pulseReset();
        startRun(8'h55, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({j1, k1} !== 2'b11) begin
                errors++;
                $display("[TB] FAIL dc_jk%0d got %b%b want 11", i, j1, k1);
            end
            tick();
            checks++;
            if (q1 !== ((i % 2) == 0)) begin
                errors++;
                $display("[TB] FAIL dc_q%0d got %b want %b", i, q1, ((i % 2) == 0));
            end
        end
        tick();
        checks++;
        if (done1 !== 1'b1 || err1 !== 1'b0 || errCount1 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL dc_done got done=%b err=%b cnt=%0d want 1 0 0", done1, err1, errCount1);
        end
    endtask

    task automatic test_loop();
        pulseReset();
        startRun(8'h0F, 1'b1);
        for (int e = 1; e <= 24; e++) begin
            if (e == 17) loop = 1'b0;
            tick();
            checks++;
            if (q0 !== (((e - 1) % 8) < 4) || busy0 !== 1'b1 || done0 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL loop_e%0d got q=%b busy=%b done=%b want q=%b busy=1 done=0",
                         e, q0, busy0, done0, (((e - 1) % 8) < 4));
            end
            if (e < 24) begin
                checks++;
                if (step0 !== 3'(e % 8)) begin
                    errors++;
                    $display("[TB] FAIL loop_step%0d got %0d want %0d", e, step0, e % 8);
                end
            end
        end
        tick();
        checks++;
        if (done0 !== 1'b1 || ready0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL loop_done got done=%b rdy=%b want 1 1", done0, ready0);
        end
        tick();
        tick();
        checks++;
        if (q0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loop_after got q=%b done=%b busy=%b want 0 0 0", q0, done0, busy0);
        end
    endtask

    task automatic test_abort();
        pulseReset();
        startRun(8'h0A, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (step0 !== 3'd3) begin
            errors++;
            $display("[TB] FAIL abort_step got %0d want 3", step0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || done0 !== 1'b0 || q0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_drain got busy=%b done=%b q=%b want 1 0 1", busy0, done0, q0);
        end
        tick();
        checks++;
        if (done0 !== 1'b1 || ready0 !== 1'b1 || err0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_done got done=%b rdy=%b err=%b want 1 1 0", done0, ready0, err0);
        end
        tick();
        tick();
        checks++;
        if (q0 !== 1'b1 || done0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_hold got q=%b done=%b want 1 0", q0, done0);
        end
    endtask

    task automatic test_async_reset();
        int doneSeen;
        pulseReset();
        forceZero = 1'b1;
        startRun(8'hB2, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (err0 !== 1'b1 || busy0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_pre got err=%b busy=%b want 1 1", err0, busy0);
        end
        forceZero = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ready0 !== 1'b1 || busy0 !== 1'b0 || {j0, k0} !== 2'b00 || err0 !== 1'b0 ||
            errCount0 !== 8'd0 || step0 !== 3'd0 || done0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL areset_now got rdy=%b busy=%b jk=%b%b err=%b cnt=%0d step=%0d want 1 0 00 0 0 0",
                     ready0, busy0, j0, k0, err0, errCount0, step0);
        end
        #1 rst = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0 !== 1'b0 || ready0 !== 1'b1) doneSeen++;
        end
        checks++;
        if (doneSeen != 0) begin
            errors++;
            $display("[TB] FAIL areset_nodone got %0d bad cycles want 0", doneSeen);
        end
    endtask

    task automatic test_load_busy();
        logic [7:0] seq;
        seq = 8'hB2;
        pulseReset();
        startRun(8'hB2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin pattern = 8'h4D; load = 1'b1; end
            if (i == 4) load = 1'b0;
            tick();
            checks++;
            if (q0 !== seq[i]) begin
                errors++;
                $display("[TB] FAIL busy_q%0d got %b want %b", i, q0, seq[i]);
            end
        end
        tick();
        checks++;
        if (done0 !== 1'b1 || err0 !== 1'b0 || ready0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_done got done=%b err=%b rdy=%b want 1 0 1", done0, err0, ready0);
        end
        startRun(8'hFF, 1'b0);
        checks++;
        if (busy0 !== 1'b1 || step0 !== 3'd0) begin
            errors++;
            $display("[TB] FAIL busy_doneload got busy=%b step=%0d want 1 0", busy0, step0);
        end
        tick();
        checks++;
        if (q0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_doneload_q got %b want 1", q0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_forced_error();
        test_dc_val();
        test_loop();
        test_abort();
        test_async_reset();
        test_load_busy();
        pulseReset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Drives the J/K inputs of an external JK flip-flop so that its Q output follows a loaded LEN-bit target pattern, one bit per clock, LSB first.
- Computes J/K from the JK excitation table using the flip-flop's current Q, which is fed back on Q_fb.
- Checks each resulting Q against the target and counts mismatches.
- Acts as the stimulus/checker end of the JK flip-flop interface, for on-chip self-test of JK cells and JK-based counters.

Parameters:
- LEN, 8: pattern length in bits, 2..64.
- DC_VAL, 0: value driven on excitation-table don't-care J/K positions.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  request to start a run; accepted only when ready=1.
- pattern  in  LEN  target Q sequence; bit 0 is applied first.
- loop  in  1  repeat the pattern; sampled at each wrap edge.
- abort  in  1  stop the run after the current bit.
- Q_fb  in  1  Q output of the driven JK flip-flop.
- J  out  1  J drive (combinational).
- K  out  1  K drive (combinational).
- ready  out  1  high in IDLE.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse on return to IDLE.
- err  out  1  sticky mismatch flag.
- err_count  out  8  saturating mismatch count.
- step  out  $clog2(LEN)  index of the bit currently being driven.

Behaviour:
- Reset (async, immediate, no clock needed):
  - state=IDLE, step=0, J=K=0, ready=1, busy=0, done=0, err=0, err_count=0, chk_valid=0.
  - The pattern register clears to 0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - J=K=0.
  - Edge with load=1: latch pattern, step=0, err=0, err_count=0, chk_valid=0, go to RUN.
  - load while busy is ignored.
- RUN, combinational drive from t=pat[step] and q=Q_fb:
  - q=0, t=0: J=0, K=DC_VAL.
  - q=0, t=1: J=1, K=DC_VAL.
  - q=1, t=0: J=DC_VAL, K=1.
  - q=1, t=1: J=DC_VAL, K=0.
- RUN, at each edge:
  - exp<=t, chk_valid<=1.
  - If step==LEN-1: if loop=1, step<=0 and stay in RUN; else go to DRAIN.
  - Otherwise step<=step+1.
- abort=1 at a RUN edge: that edge's bit is still applied and recorded in exp; state goes to DRAIN regardless of step or loop.
- DRAIN:
  - J=K=0 (flip-flop holds).
  - Next edge performs the final check, then state=IDLE, chk_valid=0, done<=1 for exactly one cycle.
- Check:
  - At every edge where chk_valid=1 and Q_fb!=exp: err<=1 and err_count<=err_count+1.
  - err_count saturates at 255.
  - Q_fb is sampled before the edge, i.e. it reflects the flip-flop update at the previous edge.
- Latency: load edge E0; bits applied at E1..E_LEN; DRAIN edge E_LEN+1; done high in the cycle following E_LEN+1.
  - A run of P loop passes takes P*LEN+1 edges after E0.
- ready=1 in the done cycle; a load in that cycle is accepted.
- err and err_count hold after done until the next accepted load or reset.
- Simultaneous abort at the wrap edge: abort wins (DRAIN).
- Reset mid-run: the run is discarded, with no done pulse.

Test Plan:
- Reset, then hold rst=1 across 3 edges with load=1 -> ready=1, busy=0, J=K=0, done=0, err=0, err_count=0 throughout; deassert rst -> still IDLE.
- Bench JK model with Q reset 0; LEN=8, DC_VAL=0; load pattern=8'hB2, loop=0 ->
  - Q after E1..E8 = 0,1,0,0,1,1,0,1.
  - (J,K) during bits 0..2 = (0,0),(1,0),(0,1).
  - done pulses exactly once, in the cycle after E9.
  - err=0, err_count=0.
- Same load with bench Q_fb forced to 0 -> err=1, err_count=4 after done.
  - Next load with a healthy model -> err and err_count clear at the load edge, and the run finishes clean.
- DC_VAL=1, pattern=8'h55 from Q=0 -> J=K=1 every RUN cycle; Q toggles each edge; err=0.
- loop=1, pattern=8'h0F, 3 passes -> Q period 8 (1111_0000); busy stays high and step wraps 7->0.
  - Deassert loop during pass 3 -> done after E25; no extra bits are applied.
- abort=1 at the edge where step=3 -> DRAIN, then IDLE; done at the cycle after E5; Q holds pat[3].
  - Async rst pulse mid-RUN (between edges) -> all outputs reset immediately; no done pulse.
  - load while busy -> ignored.
